// File: rtl/stack_pkg.sv
// Shared definitions for the stack sequencer: request op codes, FSM state
// encodings and the data word width used on the shared memory bus.
package stack_pkg;

    localparam int WORD_W = 16;

    // Request op codes as presented on i_req_op.
    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_PEEK = 2'b10,
        OP_ILL  = 2'b11
    } op_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PUSH = 2'b01,
        ST_READ = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    // True when the op reads the top of stack (pop or peek).
    function automatic logic is_read_op(input op_e op);
        return (op == OP_POP) || (op == OP_PEEK);
    endfunction

endpackage

// File: rtl/wordmux.sv
// Two-input word multiplexer: out = sel ? val1 : val0.
module wordmux #(
    parameter int W = 16
) (
    input  logic         sel_i,
    input  logic [W-1:0] val1_i,
    input  logic [W-1:0] val0_i,
    output logic [W-1:0] out_o
);

    // Pure select, no state.
    assign out_o = sel_i ? val1_i : val0_i;

endmodule

// File: rtl/stack_sequencer.sv
// Initiator side of the shared-bus memory stack. Accepts push/pop/peek
// requests, sequences the memory (address, write strobe, active-low bus
// drive) and returns one response per request. Owns the stack depth count.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready for a request; address points at next free slot
// PUSH    | drive latched data on the bus and strobe the memory write
// READ    | memory drives the bus at the top-of-stack slot; capture it
// RESP    | response held on o_rsp_* until the consumer takes it
module stack_sequencer
    import stack_pkg::*;
#(
    parameter logic [WORD_W-1:0] STACK_BASE  = 16'h0000,
    parameter int                STACK_DEPTH = 256,
    localparam int               CW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_req_valid,
    input  logic [1:0]        i_req_op,
    input  logic [WORD_W-1:0] i_req_data,
    output logic              o_req_ready,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [WORD_W-1:0] o_rsp_data,
    output logic              o_rsp_err,
    output logic [WORD_W-1:0] o_mem_addr,
    output logic              o_mem_w,
    output logic              o_mem_oe_n,
    inout  wire  [WORD_W-1:0] bus,
    output logic [CW-1:0]     o_count
);

    state_e            state_q;
    op_e               op_q;
    logic [WORD_W-1:0] data_q;
    logic [CW-1:0]     count_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [WORD_W-1:0] rsp_data_q;
    logic              rsp_err_q;
    logic              mem_w_q;
    logic              mem_oe_n_q;
    logic              bus_drv_q;

    op_e               req_op;
    logic              stack_full;
    logic              stack_empty;
    logic              req_err;
    logic [WORD_W-1:0] slot;
    logic [WORD_W-1:0] bus_word;

    assign req_op      = op_e'(i_req_op);
    assign stack_full  = (count_q == CW'(STACK_DEPTH));
    assign stack_empty = (count_q == '0);

    // Requests that are answered with an error and never touch memory.
    always_comb begin
        req_err = 1'b0;
        case (req_op)
            OP_PUSH: req_err = stack_full;
            OP_POP:  req_err = stack_empty;
            OP_PEEK: req_err = stack_empty;
            default: req_err = 1'b1;
        endcase
    end

    // Empty-ascending pointer: next free slot, or the top entry while reading.
    // The 16-bit add wraps past 16'hFFFF by construction.
    always_comb begin
        slot = WORD_W'(count_q);
        if (state_q == ST_READ) begin
            slot = WORD_W'(count_q) - WORD_W'(1);
        end
    end

    assign o_mem_addr = STACK_BASE + slot;

    // Bus data path; only selects the latched word while in PUSH.
    wordmux #(
        .W(WORD_W)
    ) u_bus_mux (
        .sel_i  (bus_drv_q),
        .val1_i (data_q),
        .val0_i ('0),
        .out_o  (bus_word)
    );

    // The block releases the bus everywhere except PUSH, so it can never
    // fight the memory, which only drives while o_mem_oe_n is low in READ.
    assign bus = bus_drv_q ? bus_word : 'z;

    // Sequencer FSM with registered handshake and memory control outputs.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_PUSH;
            data_q      <= '0;
            count_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            mem_w_q     <= 1'b0;
            mem_oe_n_q  <= 1'b1;
            bus_drv_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        op_q        <= req_op;
                        data_q      <= i_req_data;
                        req_ready_q <= 1'b0;
                        if (req_err) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                        end else if (req_op == OP_PUSH) begin
                            state_q   <= ST_PUSH;
                            mem_w_q   <= 1'b1;
                            bus_drv_q <= 1'b1;
                        end else begin
                            state_q    <= ST_READ;
                            mem_oe_n_q <= 1'b0;
                        end
                    end
                end
                ST_PUSH: begin
                    count_q     <= count_q + CW'(1);
                    mem_w_q     <= 1'b0;
                    bus_drv_q   <= 1'b0;
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= '0;
                end
                ST_READ: begin
                    rsp_data_q <= bus;
                    if (op_q == OP_POP) begin
                        count_q <= count_q - CW'(1);
                    end
                    mem_oe_n_q  <= 1'b1;
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= '0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = req_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_mem_w     = mem_w_q;
    assign o_mem_oe_n  = mem_oe_n_q;
    assign o_count     = count_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer with a behavioural memory on the shared bus.
// Expected responses and memory writes come from a small stack model and are
// queued when a request is accepted, then compared as the DUT produces them.
module tb_stack_sequencer;
    import stack_pkg::*;

    localparam logic [15:0] BASE  = 16'hFFFE;
    localparam int          DEPTH = 4;
    localparam int          CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [15:0]   data;
        logic          err;
        logic [CW-1:0] count;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req_valid = 1'b0;
    logic [1:0]    i_req_op = 2'b00;
    logic [15:0]   i_req_data = 16'h0;
    logic          i_rsp_ready = 1'b0;
    logic          o_req_ready, o_rsp_valid, o_rsp_err, o_mem_w, o_mem_oe_n;
    logic [15:0]   o_rsp_data, o_mem_addr;
    logic [CW-1:0] o_count;
    wire  [15:0]   bus;

    logic [15:0] mem [0:65535];
    exp_t        sb[$];
    logic [15:0] m_stack[$];
    logic [31:0] exp_wr[$];
    logic [31:0] wr_obs[$];

    int n_pass = 0, n_total = 0;
    int mem_w_cnt = 0, oe_cnt = 0, rv_cnt = 0, viol_cnt = 0, wr_cnt = 0;

    always #5 clk = ~clk;

    stack_sequencer #(
        .STACK_BASE  (BASE),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_req_valid (i_req_valid),
        .i_req_op    (i_req_op),
        .i_req_data  (i_req_data),
        .o_req_ready (o_req_ready),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_data  (o_rsp_data),
        .o_rsp_err   (o_rsp_err),
        .o_mem_addr  (o_mem_addr),
        .o_mem_w     (o_mem_w),
        .o_mem_oe_n  (o_mem_oe_n),
        .bus         (bus),
        .o_count     (o_count)
    );

    // Memory side of the bus: drives only while its output enable is low.
    assign bus = (!o_mem_oe_n) ? mem[o_mem_addr] : 16'bz;

    always @(posedge clk) begin
        if (o_mem_w) begin
            mem[o_mem_addr] = bus;
            wr_obs.push_back({o_mem_addr, bus});
            wr_cnt++;
        end
    end

    always @(negedge clk) begin
        if (o_mem_w) mem_w_cnt++;
        if (!o_mem_oe_n) oe_cnt++;
        if (o_rsp_valid) rv_cnt++;
        if (dut.bus_drv_q && !o_mem_oe_n) viol_cnt++;
        if (o_mem_w && !o_mem_oe_n) viol_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    // Issue one request and record what the stack model says it should return.
    task automatic do_req(input logic [1:0] op, input logic [15:0] d);
        exp_t        e;
        int          n = 0;
        logic [15:0] a;
        while (!o_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!o_req_ready) begin
            n_total++;
            $display("FAIL req_ready_timeout: got ready=0 required 1");
            return;
        end
        i_req_valid = 1'b1;
        i_req_op    = op;
        i_req_data  = d;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        e.data = 16'h0;
        e.err  = 1'b0;
        case (op)
            2'b00: begin
                if (m_stack.size() == DEPTH) e.err = 1'b1;
                else begin
                    a = BASE + 16'(m_stack.size());
                    exp_wr.push_back({a, d});
                    m_stack.push_back(d);
                end
            end
            2'b01: if (m_stack.size() == 0) e.err = 1'b1; else e.data = m_stack.pop_back();
            2'b10: if (m_stack.size() == 0) e.err = 1'b1; else e.data = m_stack[$];
            default: e.err = 1'b1;
        endcase
        e.count = CW'(m_stack.size());
        sb.push_back(e);
    endtask

    // Wait for the next response, compare it with the oldest queued entry, consume it.
    task automatic get_rsp(input string tag);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!o_rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (!o_rsp_valid || sb.size() == 0) begin
            $display("FAIL %s rsp_valid: got valid=%0b queued=%0d required valid=1 with entry", tag, o_rsp_valid, sb.size());
            return;
        end
        n_pass++;
        e = sb.pop_front();
        n_total++;
        if (o_rsp_data !== e.data) $display("FAIL %s rsp_data: got %h required %h", tag, o_rsp_data, e.data);
        else n_pass++;
        n_total++;
        if (o_rsp_err !== e.err) $display("FAIL %s rsp_err: got %0b required %0b", tag, o_rsp_err, e.err);
        else n_pass++;
        n_total++;
        if (o_count !== e.count) $display("FAIL %s count: got %0d required %0d", tag, o_count, e.count);
        else n_pass++;
        i_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        i_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({o_req_ready, o_rsp_valid, o_rsp_err, o_mem_w, o_mem_oe_n} !== 5'b10001)
            $display("FAIL reset_ctrl: got rdy/vld/err/w/oe_n=%b required 10001",
                     {o_req_ready, o_rsp_valid, o_rsp_err, o_mem_w, o_mem_oe_n});
        else n_pass++;
        n_total++;
        if ({o_mem_addr, o_rsp_data, o_count} !== {BASE, 16'h0, CW'(0)})
            $display("FAIL reset_data: got addr=%h data=%h count=%0d required %h 0000 0", o_mem_addr, o_rsp_data, o_count, BASE);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_push_pop();
        wr_obs.delete();
        exp_wr.delete();
        do_req(2'b00, 16'hA5A5); get_rsp("push_a5a5");
        n_total++;
        if (o_mem_addr !== 16'hFFFF) $display("FAIL idle_addr: got %h required FFFF", o_mem_addr);
        else n_pass++;
        do_req(2'b00, 16'h1234); get_rsp("push_1234");
        do_req(2'b01, 16'h0);    get_rsp("pop_1234");
        do_req(2'b01, 16'h0);    get_rsp("pop_a5a5");
        n_total++;
        if (wr_obs.size() != exp_wr.size() || wr_obs.size() != 2)
            $display("FAIL pp_write_count: got %0d required %0d", wr_obs.size(), exp_wr.size());
        else n_pass++;
        for (int i = 0; i < wr_obs.size() && i < exp_wr.size(); i++) begin
            n_total++;
            if (wr_obs[i] !== exp_wr[i]) $display("FAIL pp_write%0d: got addr/data %h required %h", i, wr_obs[i], exp_wr[i]);
            else n_pass++;
        end
    endtask

    task automatic test_errors();
        int wc = mem_w_cnt, oc = oe_cnt;
        do_req(2'b01, 16'h0);    get_rsp("pop_empty");
        do_req(2'b11, 16'hFFFF); get_rsp("illegal_op");
        n_total++;
        if (mem_w_cnt != wc || oe_cnt != oc)
            $display("FAIL err_no_mem: got w_cycles=%0d oe_cycles=%0d required 0 0", mem_w_cnt - wc, oe_cnt - oc);
        else n_pass++;
    endtask

    task automatic test_full();
        wr_obs.delete();
        exp_wr.delete();
        for (int i = 1; i <= 5; i++) begin
            do_req(2'b00, 16'(i * 16'h1111));
            get_rsp("push_full");
        end
        do_req(2'b10, 16'h0); get_rsp("peek_full");
        for (int i = 0; i < 4; i++) begin
            do_req(2'b01, 16'h0);
            get_rsp("pop_drain");
        end
        n_total++;
        if (wr_obs.size() != exp_wr.size() || wr_obs.size() != 4)
            $display("FAIL full_write_count: got %0d required %0d", wr_obs.size(), exp_wr.size());
        else n_pass++;
        for (int i = 0; i < wr_obs.size() && i < exp_wr.size(); i++) begin
            n_total++;
            if (wr_obs[i] !== exp_wr[i]) $display("FAIL full_write%0d: got %h required %h", i, wr_obs[i], exp_wr[i]);
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        int n = 0;
        do_req(2'b00, 16'hBEEF);
        while (!o_rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        i_req_valid = 1'b1;
        i_req_op    = 2'b01;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_total++;
            if ({o_rsp_valid, o_req_ready, o_rsp_err, o_rsp_data} !== {1'b1, 1'b0, 1'b0, 16'h0})
                $display("FAIL hold_cycle%0d: got vld=%0b rdy=%0b err=%0b data=%h required 1 0 0 0000",
                         c, o_rsp_valid, o_req_ready, o_rsp_err, o_rsp_data);
            else n_pass++;
        end
        i_req_valid = 1'b0;
        get_rsp("hold_push");
        repeat (3) @(negedge clk);
        n_total++;
        if (o_rsp_valid !== 1'b0 || o_count !== CW'(1))
            $display("FAIL hold_no_stray: got vld=%0b count=%0d required 0 1", o_rsp_valid, o_count);
        else n_pass++;
        do_req(2'b01, 16'h0); get_rsp("hold_pop");
    endtask

    task automatic test_reset_mid_push();
        int wc, rc;
        do_req(2'b00, 16'h6666); get_rsp("pre_reset_push");
        do_req(2'b00, 16'h7777);
        wc = wr_cnt;
        n_total++;
        if (o_mem_w !== 1'b1) $display("FAIL mid_push_w: got %0b required 1", o_mem_w);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({o_mem_w, dut.bus_drv_q, o_rsp_valid, o_mem_oe_n} !== 4'b0001 || o_count !== CW'(0))
            $display("FAIL reset_abort: got w/drv/vld/oe_n=%b count=%0d required 0001 0",
                     {o_mem_w, dut.bus_drv_q, o_rsp_valid, o_mem_oe_n}, o_count);
        else n_pass++;
        sb.delete();
        m_stack.delete();
        exp_wr.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rc = rv_cnt;
        repeat (4) @(negedge clk);
        n_total++;
        if (wr_cnt != wc || rv_cnt != rc || o_mem_addr !== BASE)
            $display("FAIL reset_after: got writes=%0d rsp_cycles=%0d addr=%h required 0 0 %h",
                     wr_cnt - wc, rv_cnt - rc, o_mem_addr, BASE);
        else n_pass++;
    endtask

    task automatic test_wrap();
        wr_obs.delete();
        exp_wr.delete();
        do_req(2'b00, 16'h0101); get_rsp("wrap_push0");
        do_req(2'b00, 16'h0202); get_rsp("wrap_push1");
        do_req(2'b00, 16'h0303); get_rsp("wrap_push2");
        n_total++;
        if (wr_obs.size() != 3 || wr_obs[2][31:16] !== 16'h0000)
            $display("FAIL wrap_addr: got %0d writes last=%h required 3 writes last addr 0000",
                     wr_obs.size(), (wr_obs.size() > 0) ? wr_obs[$] : 32'h0);
        else n_pass++;
        for (int i = 0; i < wr_obs.size() && i < exp_wr.size(); i++) begin
            n_total++;
            if (wr_obs[i] !== exp_wr[i]) $display("FAIL wrap_write%0d: got %h required %h", i, wr_obs[i], exp_wr[i]);
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            do_req(2'b01, 16'h0);
            get_rsp("wrap_pop");
        end
    endtask

    task automatic test_bus_safety();
        n_total++;
        if (viol_cnt != 0) $display("FAIL bus_contention: got %0d cycles required 0", viol_cnt);
        else n_pass++;
        n_total++;
        if (sb.size() != 0) $display("FAIL leftover_rsp: got %0d pending required 0", sb.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_errors();
        test_full();
        test_hold();
        test_reset_mid_push();
        test_wrap();
        test_bus_safety();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
